jpeg_lane_parity_pipe: RTL and testbench

Streaming, multi-lane parity generator for the JPEG datapath timing cones. It generalises the three-input XNOR parity cone to LANES independent lanes of DATA_W bits each. Each beat moves through a two-stage valid/ready pipeline. Optionally, per-lane parity is accumulated across a packet delimited by `in_last`. It sits between the entropy-coder byte stream and the integrity checker.

---
 rtl/jpeg_par_pkg.sv | 20 ++
 rtl/jpeg_lane_parity_reduce.sv | 16 +
 rtl/jpeg_lane_parity_pipe.sv | 142 ++++++++++++++
 tb/tb_jpeg_lane_parity_pipe.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_par_pkg.sv
// ---------------------------------------------------------------------------
// jpeg_par_pkg
// Shared constants and types for the JPEG lane parity pipeline.
//   PKT_CNT_W   : width of the packet beat counter
//   PKT_CNT_MAX : saturation value of the beat counter
//   lane_par_t  : one lane's parity bit; used as lane_par_t [LANES-1:0]
//   sat_inc()   : saturating increment of a beat count
// ---------------------------------------------------------------------------
package jpeg_par_pkg;

    localparam int PKT_CNT_W = 16;
    localparam logic [PKT_CNT_W-1:0] PKT_CNT_MAX = '1;

    typedef logic lane_par_t;

    function automatic logic [PKT_CNT_W-1:0] sat_inc(input logic [PKT_CNT_W-1:0] c);
        return (c == PKT_CNT_MAX) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/jpeg_lane_parity_reduce.sv
// ---------------------------------------------------------------------------
// jpeg_lane_parity_reduce
// Combinational XOR reduction of one DATA_W-bit lane.
//   lane_i : lane data
//   par_o  : raw (non-inverted) parity of lane_i
// ---------------------------------------------------------------------------
module jpeg_lane_parity_reduce #(
    parameter int DATA_W = 3
) (
    input  logic [DATA_W-1:0] lane_i,
    output logic              par_o
);

    assign par_o = ^lane_i;

endmodule

// File: rtl/jpeg_lane_parity_pipe.sv
// ---------------------------------------------------------------------------
// jpeg_lane_parity_pipe
// Two-stage valid/ready pipeline computing per-lane parity of LANES lanes of
// DATA_W bits. Stage 1 holds the raw XOR reduction, stage 2 the (optionally
// inverted) parity presented on out_par.
//   clk, rst                 : clock, asynchronous active-high reset
//   in_valid/in_ready        : input handshake, in_data lane i at [i*DATA_W +: DATA_W]
//   in_last                  : final beat of a packet
//   out_valid/out_ready      : output handshake, out_par / out_last
//   pkt_valid/pkt_par/pkt_beats : packet parity result, one-cycle pulse
// Optional feature: define JPEG_PAR_ACCUM_EN to build the packet accumulator;
// otherwise the pkt_* ports are tied to zero.
// ---------------------------------------------------------------------------
module jpeg_lane_parity_pipe
    import jpeg_par_pkg::*;
#(
    parameter int DATA_W = 3,
    parameter int LANES  = 4,
    parameter bit INVERT = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*DATA_W-1:0]  in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES-1:0]         out_par,
    output logic                     out_last,
    output logic                     pkt_valid,
    output logic [LANES-1:0]         pkt_par,
    output logic [PKT_CNT_W-1:0]     pkt_beats
);

    localparam lane_par_t [LANES-1:0] INV_VEC = {LANES{INVERT}};

    lane_par_t [LANES-1:0] raw_par;
    lane_par_t [LANES-1:0] s1_raw_q;
    lane_par_t [LANES-1:0] s2_par_q;
    logic      [2:1]       vld_q;
    logic                  s1_last_q;
    logic                  s2_last_q;
    logic                  en1;
    logic                  en2;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        jpeg_lane_parity_reduce #(.DATA_W(DATA_W)) u_red (
            .lane_i (in_data[g*DATA_W +: DATA_W]),
            .par_o  (raw_par[g])
        );
    end

    assign en2      = ~vld_q[2] | out_ready;
    assign en1      = ~vld_q[1] | en2;
    // Held low during reset so no beat is accepted while state is cleared.
    assign in_ready = en1 & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q     <= '0;
            s1_raw_q  <= '0;
            s1_last_q <= 1'b0;
            s2_par_q  <= '0;
            s2_last_q <= 1'b0;
        end else begin
            if (en1) begin
                vld_q[1] <= in_valid;
                if (in_valid) begin
                    s1_raw_q  <= raw_par;
                    s1_last_q <= in_last;
                end
            end
            if (en2) begin
                vld_q[2] <= vld_q[1];
                if (vld_q[1]) begin
                    // Inversion is registered so out_par is 0 out of reset
                    // regardless of INVERT.
                    s2_par_q  <= s1_raw_q ^ INV_VEC;
                    s2_last_q <= s1_last_q;
                end
            end
        end
    end

    assign out_valid = vld_q[2];
    assign out_par   = s2_par_q;
    assign out_last  = s2_last_q;

`ifdef JPEG_PAR_ACCUM_EN
    lane_par_t [LANES-1:0] acc_q, acc_d;
    lane_par_t [LANES-1:0] pkt_par_q, pkt_par_d;
    logic [PKT_CNT_W-1:0]  cnt_q, cnt_d;
    logic [PKT_CNT_W-1:0]  beats_q, beats_d;
    logic                  pkt_vld_q, pkt_vld_d;

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        pkt_par_d = pkt_par_q;
        beats_d   = beats_q;
        pkt_vld_d = 1'b0;
        if (out_valid && out_ready) begin
            // Accumulate raw parity; undo the stage-2 inversion first.
            acc_d = acc_q ^ (s2_par_q ^ INV_VEC);
            cnt_d = sat_inc(cnt_q);
            if (s2_last_q) begin
                pkt_par_d = acc_d ^ INV_VEC;
                beats_d   = cnt_d;
                pkt_vld_d = 1'b1;
                acc_d     = '0;
                cnt_d     = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            pkt_par_q <= '0;
            beats_q   <= '0;
            pkt_vld_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            pkt_par_q <= pkt_par_d;
            beats_q   <= beats_d;
            pkt_vld_q <= pkt_vld_d;
        end
    end

    assign pkt_valid = pkt_vld_q;
    assign pkt_par   = pkt_par_q;
    assign pkt_beats = beats_q;
`else
    assign pkt_valid = 1'b0;
    assign pkt_par   = '0;
    assign pkt_beats = '0;
`endif

endmodule

// File: tb/tb_jpeg_lane_parity_pipe.sv
module tb_jpeg_lane_parity_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;
    logic [11:0] data_b;
    logic [2:0]  data_a;

    logic        in_ready_a, out_valid_a, out_last_a, pkt_valid_a;
    logic [0:0]  out_par_a, pkt_par_a;
    logic [15:0] pkt_beats_a;
    logic        in_ready_b, out_valid_b, out_last_b, pkt_valid_b;
    logic [3:0]  out_par_b, pkt_par_b;
    logic [15:0] pkt_beats_b;

    assign data_a = data_b[2:0];

    always #5 clk = ~clk;

    // a: one lane, XNOR; b: four lanes, XOR. Both share the handshake controls.
    jpeg_lane_parity_pipe #(.DATA_W(3), .LANES(1), .INVERT(1'b1)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(data_a), .in_last(in_last), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_par(out_par_a), .out_last(out_last_a),
        .pkt_valid(pkt_valid_a), .pkt_par(pkt_par_a), .pkt_beats(pkt_beats_a)
    );

    jpeg_lane_parity_pipe #(.DATA_W(3), .LANES(4), .INVERT(1'b0)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(data_b), .in_last(in_last), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_par(out_par_b), .out_last(out_last_b),
        .pkt_valid(pkt_valid_b), .pkt_par(pkt_par_b), .pkt_beats(pkt_beats_b)
    );

    // Output and packet monitors (sampled away from the active edge).
    logic [4:0]  qb[$];
    logic [0:0]  qa[$];
    logic [3:0]  pq_par[$];
    logic [15:0] pq_beats[$];

    always @(negedge clk) begin
        if (out_valid_b && out_ready) begin
            qb.push_back({out_last_b, out_par_b});
            qa.push_back(out_par_a);
        end
        if (pkt_valid_b) begin
            pq_par.push_back(pkt_par_b);
            pq_beats.push_back(pkt_beats_b);
        end
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [11:0] d, input logic l);
        bit rdy;
        in_valid = 1'b1;
        data_b   = d;
        in_last  = l;
        rdy      = 1'b0;
        for (int b = 0; b < 100 && !rdy; b++) begin
            @(negedge clk);
            rdy = in_ready_b;
            @(posedge clk); #1;
        end
        if (!rdy) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_q(input int n);
        for (int b = 0; b < 200 && qb.size() < n; b++) begin
            @(posedge clk); #1;
        end
        chk("drain_count", qb.size(), n);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; data_b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic chk_pkt(input string nm, input int pb, input logic [3:0] ep, input logic [15:0] eb);
`ifdef JPEG_PAR_ACCUM_EN
        chk({nm, "_pulses"}, pq_par.size() - pb, 1);
        if (pq_par.size() > pb) begin
            chk({nm, "_par"}, pq_par[pb], ep);
            chk({nm, "_beats"}, pq_beats[pb], eb);
        end
`else
        chk({nm, "_pulses"}, pq_par.size() - pb, 0);
        chk({nm, "_par_tied"}, pkt_par_b, 4'h0);
        chk({nm, "_beats_tied"}, pkt_beats_b, 16'h0);
        if (ep === eb[3:0] && ep !== ep) $display("unreachable");
`endif
    endtask

    typedef struct {
        logic [11:0] d;
        logic        last;
        logic [3:0]  exp_b;
        logic        exp_a;
    } vec_t;

    vec_t        tbl[8];
    logic [2:0]  lat_d[4];
    logic        lat_e[4];
    logic [3:0]  ep[4];
    logic [15:0] eb[4];
    int          base, pb;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{12'hF0F, 1'b1, 4'b1111, 1'b0};
        tbl[1] = '{12'h801, 1'b1, 4'b1001, 1'b0};
        tbl[2] = '{12'h000, 1'b0, 4'b0000, 1'b1};
        tbl[3] = '{12'hFFF, 1'b0, 4'b1111, 1'b0};
        tbl[4] = '{12'h249, 1'b0, 4'b1111, 1'b0};
        tbl[5] = '{12'h0DB, 1'b0, 4'b0000, 1'b1};
        tbl[6] = '{12'hA5C, 1'b1, 4'b0101, 1'b0};
        tbl[7] = '{12'h007, 1'b1, 4'b0001, 1'b0};
        ep[0] = 4'hF; ep[1] = 4'h9; ep[2] = 4'h5; ep[3] = 4'h1;
        eb[0] = 16'd1; eb[1] = 16'd1; eb[2] = 16'd5; eb[3] = 16'd1;
        lat_d[0] = 3'b000; lat_d[1] = 3'b001; lat_d[2] = 3'b011; lat_d[3] = 3'b111;
        lat_e[0] = 1'b1;   lat_e[1] = 1'b0;   lat_e[2] = 1'b1;   lat_e[3] = 1'b0;

        // Reset values.
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; data_b = '0; out_ready = 1'b1;
        #2;
        chk("rst_in_ready", in_ready_b, 1'b0);
        chk("rst_out_valid", out_valid_b, 1'b0);
        chk("rst_out_par_a", out_par_a, 1'b0);
        chk("rst_out_par_b", out_par_b, 4'h0);
        chk("rst_out_last", out_last_b, 1'b0);
        chk("rst_pkt_valid", pkt_valid_b, 1'b0);
        chk("rst_pkt_par", pkt_par_b, 4'h0);
        chk("rst_pkt_beats", pkt_beats_b, 16'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready_b, 1'b1);
        chk("post_rst_out_par_a", out_par_a, 1'b0);
        @(posedge clk); #1;

        // Two-cycle latency, one lane XNOR.
        pb = pq_par.size();
        for (int c = 0; c < 7; c++) begin
            if (c < 4) begin
                in_valid = 1'b1; data_b = {9'b0, lat_d[c]}; in_last = (c == 3);
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
            @(negedge clk);
            if (c >= 2 && c <= 5) begin
                chk("lat_valid", out_valid_a, 1'b1);
                chk("lat_par_a", out_par_a, lat_e[c-2]);
            end else begin
                chk("lat_idle", out_valid_a, 1'b0);
            end
            @(posedge clk); #1;
        end
        repeat (2) @(posedge clk); #1;
        chk_pkt("lat_pkt", pb, 4'h0, 16'd4);

        // Table-driven vectors, full throughput.
        do_reset();
        base = qb.size(); pb = pq_par.size();
        for (int i = 0; i < 8; i++) send(tbl[i].d, tbl[i].last);
        in_valid = 1'b0;
        wait_q(base + 8);
        for (int i = 0; i < 8; i++) begin
            if (qb.size() > base + i) begin
                chk($sformatf("tbl%0d_par_b", i), qb[base+i][3:0], tbl[i].exp_b);
                chk($sformatf("tbl%0d_last", i), qb[base+i][4], tbl[i].last);
                chk($sformatf("tbl%0d_par_a", i), qa[base+i], tbl[i].exp_a);
            end
        end
        repeat (3) @(posedge clk); #1;
`ifdef JPEG_PAR_ACCUM_EN
        chk("tbl_pkt_pulses", pq_par.size() - pb, 4);
        for (int k = 0; k < 4; k++) begin
            if (pq_par.size() > pb + k) begin
                chk($sformatf("tbl_pkt%0d_par", k), pq_par[pb+k], ep[k]);
                chk($sformatf("tbl_pkt%0d_beats", k), pq_beats[pb+k], eb[k]);
            end
        end
`else
        chk("tbl_pkt_pulses", pq_par.size() - pb, 0);
        chk("tbl_pkt_beats_tied", pkt_beats_b, 16'h0);
`endif

        // Backpressure: out_ready low during cycles 3..7.
        do_reset();
        base = qb.size(); pb = pq_par.size();
        fork
            begin
                send(12'h001, 1'b0);
                send(12'h008, 1'b0);
                send(12'h040, 1'b0);
                send(12'h200, 1'b0);
                send(12'h249, 1'b0);
                send(12'h000, 1'b1);
                in_valid = 1'b0; in_last = 1'b0;
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    out_ready = !(c >= 3 && c <= 7);
                    @(negedge clk);
                    if (c == 5 || c == 7) begin
                        chk("bp_in_ready", in_ready_b, 1'b0);
                        chk("bp_out_valid", out_valid_b, 1'b1);
                        chk("bp_stable_par", out_par_b, 4'b0010);
                    end
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_q(base + 6);
        if (qb.size() >= base + 6) begin
            chk("bp_b0", qb[base+0], 5'b0_0001);
            chk("bp_b1", qb[base+1], 5'b0_0010);
            chk("bp_b2", qb[base+2], 5'b0_0100);
            chk("bp_b3", qb[base+3], 5'b0_1000);
            chk("bp_b4", qb[base+4], 5'b0_1111);
            chk("bp_b5", qb[base+5], 5'b1_0000);
        end
        repeat (3) @(posedge clk); #1;
        chk_pkt("bp_pkt", pb, 4'h0, 16'd6);

        // Three-beat packet on lane 0.
        do_reset();
        base = qb.size(); pb = pq_par.size();
        send(12'h001, 1'b0);
        send(12'h001, 1'b0);
        send(12'h001, 1'b1);
        in_valid = 1'b0; in_last = 1'b0;
        wait_q(base + 3);
        for (int i = 0; i < 3; i++)
            if (qb.size() > base + i)
                chk($sformatf("p3_beat%0d", i), qb[base+i], {(i == 2), 4'b0001});
        repeat (4) @(posedge clk); #1;
        chk_pkt("p3_pkt", pb, 4'b0001, 16'd3);

        // Reset in the middle of a packet.
        do_reset();
        base = qb.size();
        send(12'h001, 1'b0);
        send(12'h001, 1'b0);
        send(12'h001, 1'b0);
        in_valid = 1'b0;
        wait_q(base + 2);
        chk("mid_pre_valid", out_valid_b, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid_b, 1'b0);
        chk("mid_rst_pkt_valid", pkt_valid_b, 1'b0);
        chk("mid_rst_in_ready", in_ready_b, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        base = qb.size(); pb = pq_par.size();
        send(12'h002, 1'b1);
        in_valid = 1'b0; in_last = 1'b0;
        wait_q(base + 1);
        if (qb.size() > base) chk("mid_new_beat", qb[base], 5'b1_0001);
        repeat (4) @(posedge clk); #1;
        chk_pkt("mid_pkt", pb, 4'b0001, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
